// File: rtl/div32x32.sv
// rtl/div32x32.sv - 32-bit unsigned restoring divider, one quotient bit per cycle
module div32x32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        dbz,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] q_reg;
  logic [31:0] rem_reg;
  logic [31:0] b_reg;
  logic [4:0]  cnt;
  logic        dbz_reg;

  // q_reg starts as the dividend; each step shifts its MSB into the partial
  // remainder and shifts the new quotient bit in at the bottom.
  logic [32:0] shifted;
  logic [32:0] trial;
  logic        borrow;

  assign shifted = {rem_reg, q_reg[31]};
  assign trial   = shifted - {1'b0, b_reg};
  // rem_reg < b_reg always holds, so bit 32 of the 33-bit difference is the borrow.
  assign borrow  = trial[32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      q_reg   <= 32'd0;
      rem_reg <= 32'd0;
      b_reg   <= 32'd0;
      cnt     <= 5'd0;
      dbz_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (b != 32'd0) begin
              q_reg   <= a;
              b_reg   <= b;
              rem_reg <= 32'd0;
              cnt     <= 5'd31;
              dbz_reg <= 1'b0;
              state   <= CALC;
            end else begin
              q_reg   <= 32'hFFFF_FFFF;
              rem_reg <= a;
              dbz_reg <= 1'b1;
              state   <= DONE;
            end
          end
        end
        CALC: begin
          rem_reg <= borrow ? shifted[31:0] : trial[31:0];
          q_reg   <= {q_reg[30:0], ~borrow};
          if (cnt == 5'd0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state == CALC);
  assign done      = (state == DONE);
  assign dbz       = dbz_reg;
  assign quotient  = q_reg;
  assign remainder = rem_reg;

endmodule

// File: tb/tb_div32x32.sv
// tb/tb_div32x32.sv - directed and random checks of div32x32 results and timing
module tb_div32x32;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_vec;
  int n_fail;
  int busy_cnt;
  int done_cyc;
  int done_cnt;
  int overlap;

  div32x32 dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start a division at the next IDLE negedge and watch cycles 1..40 until done.
  task automatic run(input logic [31:0] av, input logic [31:0] bv, input bit hold);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    busy_cnt = 0;
    done_cyc = 0;
    done_cnt = 0;
    overlap  = 0;
    for (int k = 1; k <= 40 && done_cyc == 0; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
      if (done) begin
        done_cyc = k;
        done_cnt++;
      end else if (hold) begin
        a = $urandom;
        b = $urandom;
      end
    end
  endtask

  task automatic expect_result(input string tag, input logic [31:0] bv,
                               input logic [31:0] q, input logic [31:0] r);
    chk({tag, ".busy_cycles"}, busy_cnt, (bv == 32'd0) ? 32'd0 : 32'd32);
    chk({tag, ".done_cycle"}, done_cyc, (bv == 32'd0) ? 32'd1 : 32'd33);
    chk({tag, ".overlap"}, overlap, 32'd0);
    chk({tag, ".quotient"}, quotient, q);
    chk({tag, ".remainder"}, remainder, r);
    chk({tag, ".dbz"}, {31'd0, dbz}, {31'd0, (bv == 32'd0)});
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    n_vec  = 0;
    n_fail = 0;
    reset  = 1'b1;
    start  = 1'b0;
    a      = 32'd0;
    b      = 32'd0;

    @(negedge clk);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.done", {31'd0, done}, 32'd0);
    chk("reset.dbz", {31'd0, dbz}, 32'd0);
    chk("reset.quotient", quotient, 32'd0);
    chk("reset.remainder", remainder, 32'd0);
    reset = 1'b0;

    run(32'd100, 32'd7, 1'b0);
    expect_result("d100_7", 32'd7, 32'd14, 32'd2);

    // Results hold through idle cycles with start low.
    repeat (3) @(negedge clk);
    chk("hold.quotient", quotient, 32'd14);
    chk("hold.remainder", remainder, 32'd2);
    chk("hold.busy", {31'd0, busy}, 32'd0);

    run(32'hFFFF_FFFF, 32'd1, 1'b0);
    expect_result("dmax_1", 32'd1, 32'hFFFF_FFFF, 32'd0);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    expect_result("dmax_max", 32'hFFFF_FFFF, 32'd1, 32'd0);

    run(32'd5, 32'd0, 1'b0);
    expect_result("dbz5", 32'd0, 32'hFFFF_FFFF, 32'd5);

    run(32'd0, 32'd9, 1'b0);
    expect_result("d0_9", 32'd9, 32'd0, 32'd0);
    run(32'h8000_0000, 32'h8000_0001, 1'b0);
    expect_result("dlt", 32'h8000_0001, 32'd0, 32'h8000_0000);

    // start held high with operands toggling while busy
    run(32'd3, 32'd10, 1'b1);
    expect_result("held", 32'd10, 32'd0, 32'd3);
    chk("held.done_count", done_cnt, 32'd1);
    a = 32'd50;
    b = 32'd6;
    @(negedge clk);
    chk("held.idle_busy", {31'd0, busy}, 32'd0);
    chk("held.idle_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("held.reaccept_busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    done_cyc = 0;
    for (int k = 2; k <= 40 && done_cyc == 0; k++) begin
      @(negedge clk);
      if (done) done_cyc = k;
    end
    chk("held2.done_cycle", done_cyc, 32'd33);
    chk("held2.quotient", quotient, 32'd8);
    chk("held2.remainder", remainder, 32'd2);

    // Reset in cycle 10 of CALC
    @(negedge clk);
    a = 32'd12345;
    b = 32'd11;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_mid.busy_before", {31'd0, busy}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid.busy", {31'd0, busy}, 32'd0);
    chk("rst_mid.done", {31'd0, done}, 32'd0);
    chk("rst_mid.dbz", {31'd0, dbz}, 32'd0);
    chk("rst_mid.quotient", quotient, 32'd0);
    chk("rst_mid.remainder", remainder, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    chk("rst_mid.no_activity", done_cnt, 32'd0);
    run(32'd1000, 32'd33, 1'b0);
    expect_result("d1000_33", 32'd33, 32'd30, 32'd10);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 16);
        2:       rb = ra;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run(ra, rb, 1'b0);
      if (rb == 32'd0) expect_result("rand", rb, 32'hFFFF_FFFF, ra);
      else             expect_result("rand", rb, ra / rb, ra % rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
